// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU controller: op codes, FSM states
// and 1-bit slice operation selects.
package serial_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_NOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_SLT  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] SLICE_AND = 2'b00;
  localparam logic [1:0] SLICE_OR  = 2'b01;
  localparam logic [1:0] SLICE_ADD = 2'b10;

  // Ops that run the full sequence on zeroed operands and produce all-zero outputs
  function automatic logic op_is_inert(input logic [2:0] o, input logic slt_en);
    if (o == OP_RSVD) begin
      return 1'b1;
    end else if (o == OP_SLT) begin
      return !slt_en;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice with operand inversion and AND/OR/ADD select.
module alu_slice
  import serial_alu_pkg::*;
(
  input  logic       A,
  input  logic       B,
  input  logic       Ainvert,
  input  logic       Binvert,
  input  logic       CarryIn,
  input  logic [1:0] Operation,
  output logic       Carryout,
  output logic       Result
);

  logic a_s;
  logic b_s;

  assign a_s      = A ^ Ainvert;
  assign b_s      = B ^ Binvert;
  assign Carryout = (a_s & b_s) | (a_s & CarryIn) | (b_s & CarryIn);

  // Result select for the active operation
  always_comb begin
    case (Operation)
      SLICE_AND: Result = a_s & b_s;
      SLICE_OR:  Result = a_s | b_s;
      SLICE_ADD: Result = a_s ^ b_s ^ CarryIn;
      default:   Result = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU controller: processes one operand bit per cycle, LSB first.
// Define SERIAL_ALU_SLT_EN to enable the set-less-than operation (op 110).
module bit_serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

`ifdef SERIAL_ALU_SLT_EN
  localparam logic SLT_EN = 1'b1;
`else
  localparam logic SLT_EN = 1'b0;
`endif

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state_r;
  op_e              op_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;

  logic       ainv_s;
  logic       binv_s;
  logic [1:0] sel_s;
  logic       sub_s;
  logic       arith_s;
  logic       slt_s;
  logic       cin_s;
  logic       last_s;
  logic       slice_cout_s;
  logic       slice_res_s;
  logic       inert_s;

  assign inert_s = op_is_inert(op, SLT_EN);
  assign cin_s   = (cnt_r == {CW{1'b0}}) ? sub_s : carry_r;
  assign last_s  = (cnt_r == CW'(WIDTH - 1));

  // Slice control decode from the latched op
  always_comb begin
    ainv_s  = 1'b0;
    binv_s  = 1'b0;
    sel_s   = SLICE_AND;
    sub_s   = 1'b0;
    arith_s = 1'b0;
    slt_s   = 1'b0;
    case (op_r)
      OP_AND: sel_s = SLICE_AND;
      OP_OR:  sel_s = SLICE_OR;
      OP_ADD: begin
        sel_s   = SLICE_ADD;
        arith_s = 1'b1;
      end
      OP_SUB: begin
        binv_s  = 1'b1;
        sel_s   = SLICE_ADD;
        sub_s   = 1'b1;
        arith_s = 1'b1;
      end
      OP_NOR: begin
        ainv_s = 1'b1;
        binv_s = 1'b1;
        sel_s  = SLICE_AND;
      end
      OP_NAND: begin
        ainv_s = 1'b1;
        binv_s = 1'b1;
        sel_s  = SLICE_OR;
      end
      OP_SLT: begin
        if (SLT_EN) begin
          binv_s = 1'b1;
          sel_s  = SLICE_ADD;
          sub_s  = 1'b1;
          slt_s  = 1'b1;
        end else begin
          sel_s = SLICE_AND;
        end
      end
      default: sel_s = SLICE_AND;
    endcase
  end

  alu_slice u_slice (
    .A         (a_sr_r[0]),
    .B         (b_sr_r[0]),
    .Ainvert   (ainv_s),
    .Binvert   (binv_s),
    .CarryIn   (cin_s),
    .Operation (sel_s),
    .Carryout  (slice_cout_s),
    .Result    (slice_res_s)
  );

  // Control FSM and datapath; a_sr_r doubles as the result shift register,
  // filling from the MSB as operand bits leave from the LSB
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      op_r    <= OP_AND;
      a_sr_r  <= {WIDTH{1'b0}};
      b_sr_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
            op_r    <= op_e'(op);
            a_sr_r  <= inert_s ? {WIDTH{1'b0}} : a;
            b_sr_r  <= inert_s ? {WIDTH{1'b0}} : b;
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            result  <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        ST_RUN: begin
          a_sr_r  <= {slice_res_s, a_sr_r[WIDTH-1:1]};
          b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
          carry_r <= slice_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            if (slt_s) begin
              result <= {{(WIDTH-1){1'b0}}, slice_res_s ^ cin_s ^ slice_cout_s};
              cout   <= 1'b0;
              ovf    <= 1'b0;
            end else begin
              result <= {slice_res_s, a_sr_r[WIDTH-1:1]};
              cout   <= arith_s & slice_cout_s;
              ovf    <= arith_s & (cin_s ^ slice_cout_s);
            end
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl at WIDTH=8; honours SERIAL_ALU_SLT_EN.
module tb_bit_serial_alu_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       co;
    logic       ov;
  } exp_t;

`ifdef SERIAL_ALU_SLT_EN
  localparam logic [7:0] SLT_R0 = 8'h01;
`else
  localparam logic [7:0] SLT_R0 = 8'h00;
`endif

  exp_t sb_q[$];
  vec_t tbl[13];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit_serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t add_model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [8:0] s;
    s    = {1'b0, x} + {1'b0, y};
    e.res = s[7:0];
    e.co  = s[8];
    e.ov  = (x[7] == y[7]) && (s[7] != x[7]);
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      chk({tag, "_result"}, 32'(result), 32'(x.res));
      chk({tag, "_cout"}, 32'(cout), 32'(x.co));
      chk({tag, "_ovf"}, 32'(ovf), 32'(x.ov));
    end
  endtask

  // Single operation with operands scrambled after the start edge
  task automatic run_op(input vec_t v, input string tag);
    exp_t e;
    int   lat;
    int   nbusy;
    bit   seen;
    @(negedge clk);
    op    = v.op;
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    e.res = v.res;
    e.co  = v.co;
    e.ov  = v.ov;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~v.a;
    b     = v.b ^ 8'h5A;
    lat   = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
      a = 8'($urandom);
      b = 8'($urandom);
    end
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    if (seen) begin
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      pop_check(tag);
    end else begin
      sb_q.delete();
    end
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(result), 32'(e.res));
  endtask

  initial begin
    int ndone;
    tbl[0]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tbl[1]  = '{3'b011, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    tbl[2]  = '{3'b011, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
    tbl[3]  = '{3'b100, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0};
    tbl[4]  = '{3'b101, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0};
    tbl[5]  = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    tbl[6]  = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0};
    tbl[7]  = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{3'b011, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    tbl[9]  = '{3'b010, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    tbl[10] = '{3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{3'b110, 8'h80, 8'h01, SLT_R0, 1'b0, 1'b0};
    tbl[12] = '{3'b110, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};

    // Reset with start held high: reset must win
    rst   = 1'b1;
    start = 1'b1;
    op    = 3'b010;
    a     = 8'hAA;
    b     = 8'h55;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
    end

    // Start held every cycle with changing operands
    start = 1'b1;
    op    = 3'b010;
    for (int j = 0; j < 30; j++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (j % 10 == 0) sb_q.push_back(add_model(a, b));
      @(negedge clk);
      chk($sformatf("stream_done_e%0d", j), 32'(done), 32'((j % 10) == 8));
      if (done) pop_check("stream");
    end
    start = 1'b0;
    chk("stream_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    @(negedge clk);

    // Reset during RUN bit 4 aborts with no done pulse
    op    = 3'b010;
    a     = 8'hFF;
    b     = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort_quiet", 32'(ndone), 32'd0);
    run_op(tbl[7], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
